cn_expand: RTL
==============

# cn_expand

Check-node output expander for the min-sum LDPC decoder. It is the consumer of the two-minimum merge tree: it takes one check-node summary (min1, min2, min1 edge index, incoming sign vector) and serialises it into one extrinsic message per edge. Each message is returned toward the variable nodes over a valid/ready stream. It sits between the check-node merge stage and the variable-node update memory.

## Interface
- `data_w`, default 8: magnitude width of min1, min2 and the output magnitude.
- `idx_w`, default 8: edge-index width.
- `deg`, default 8: check-node degree, meaning edges per record; range 2..2^idx_w.
- `offset`, default 1: offset value subtracted from the magnitude, used only when `CN_OFFSET_EN` is defined.

Ports:
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an input record is present.
- `in_ready` output 1: the block accepts the record this cycle.
- `min1` input data_w: smallest incoming magnitude.
- `min2` input data_w: second-smallest incoming magnitude.
- `min1_idx` input idx_w: edge index of min1.
- `sign_vec` input deg: incoming sign bits, bit e belongs to edge e (1 = negative).
- `out_valid` output 1: an output message is present.
- `out_ready` input 1: downstream takes the message.
- `out_mag` output data_w: outgoing magnitude.
- `out_sign` output 1: outgoing sign.
- `out_idx` output idx_w: edge number of the current message.
- `out_last` output 1: high on the edge deg-1 message.

## Operation
- The state machine has two states: IDLE and EMIT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch min1, min2, min1_idx and sign_vec, and compute `psign` = XOR of all of sign_vec.
  - Set edge counter e=0 and go to EMIT.
- EMIT:
  - The output registers hold edge e.
  - `out_mag` = (e==min1_idx) ? min2 : min1.
  - `out_sign` = psign ^ sign_vec[e].
  - `out_idx` = e; `out_last` = (e==deg-1).
- Handshake:
  - On `out_valid`&`out_ready` with e<deg-1: e increments and the next message is loaded.
  - On a handshake with e==deg-1: if `in_valid` is high, the new record is accepted in the same cycle and EMIT restarts at e=0; otherwise go to IDLE and deassert `out_valid`.
- `in_ready` = IDLE, or (EMIT & `out_last` & `out_ready`).
- `min1_idx` ≥ deg: no edge matches, so every edge gets min1. This is not an error.
- min1==min2: the output is identical on all edges. No special case.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` never drops without a handshake.
- Reset values: `in_ready`=0 while `rst_n`=0, then 1 (IDLE); `out_valid`, `out_mag`, `out_sign`, `out_idx` and `out_last` are all 0.
- Reset mid-record: the record is discarded, the block returns to IDLE, and no partial messages resume.

## Timing
- Acceptance at rising edge T: `out_valid`=1 with edge 0 visible after T, in cycle T+1.
- Latency from input handshake to first output is 1 cycle.
- With `out_ready` held high, edges 0..deg-1 appear in consecutive cycles T+1..T+deg.
- Back-to-back records: the next record is accepted at the edge-(deg-1) handshake, so its edge 0 follows with no bubble. Sustained throughput is 1 message per cycle.
- Every output is a register. No combinational path from `in_*` to `out_*`.
- The only combinational path from `out_ready` is to `in_ready`.

## Configuration
- `CN_OFFSET_EN` defined (offset min-sum):
  - `out_mag` = max(selected − offset, 0), saturating at 0 and never wrapping.
  - The subtraction is applied at the register stage; latency is unchanged.
- `CN_OFFSET_EN` undefined: plain min-sum; `out_mag` = the selected magnitude. The `offset` parameter is unused.

## Test plan
Unless stated otherwise, the bench uses deg=4, data_w=8, offset=1.
- **Basic record:** min1=3, min2=7, min1_idx=2, sign_vec=4'b0011, `out_ready`=1.
  - Without the macro: edges 0..3 give mag 3,3,7,3 and sign 1,1,0,0 (psign=0).
  - `out_last` is high only on edge 3; `out_valid` drops at T+5.
- **Backpressure:** same record, `out_ready` low for 3 cycles at edge 1.
  - Edge 1 holds with mag=3, sign=1, idx=1 stable; no edge is skipped or duplicated.
  - `in_ready`=0 throughout.
- **Back-to-back:** two records with `in_valid` held high.
  - The second record's edge 0 appears the cycle after the first record's edge 3.
  - 8 messages in 8 consecutive cycles.
- **Out-of-range index:** min1_idx=9, min1=5, min2=6, sign_vec=4'b0111.
  - All magnitudes are 5; signs are 0,0,0,1 (psign=1).
- **Offset (macro defined):** min1=0, min2=4, min1_idx=0.
  - Magnitudes 3,0,0,0; no wrap to 255.
- **Reset mid-record:** pull `rst_n` low during edge 1, asynchronously between clock edges.
  - Outputs go to 0 immediately.
  - After release, `in_ready`=1 and the next record starts at edge 0.

Source files
------------

// File: rtl/cn_expand.sv
// -----------------------------------------------------------------------------
// cn_expand -- check-node output expander for the min-sum LDPC decoder.
//
// Takes one check-node summary (min1, min2, index of min1, incoming sign
// vector) and serialises it into one extrinsic message per edge, edge 0 first,
// over a valid/ready stream toward the variable-node update memory.
//
// For edge e:
//   magnitude = (e == min1_idx) ? min2 : min1   (edge never sees its own value)
//   sign      = (XOR of all incoming signs) ^ sign_vec[e]
//
// Optional feature (compile-time macro CN_OFFSET_EN):
//   defined   -> offset min-sum, magnitude = max(selected - offset, 0)
//   undefined -> plain min-sum, magnitude = selected
//
// Parameters:
//   data_w  magnitude width
//   idx_w   edge-index width
//   deg     edges per record (2 .. 2**idx_w)
//   offset  value subtracted from the magnitude when CN_OFFSET_EN is defined
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input record present
//   in_ready   record accepted this cycle (IDLE, or last edge being taken)
//   min1       smallest incoming magnitude
//   min2       second-smallest incoming magnitude
//   min1_idx   edge index of min1 (>= deg means no edge matches)
//   sign_vec   incoming signs, bit e belongs to edge e (1 = negative)
//   out_valid  output message present
//   out_ready  downstream takes the message
//   out_mag    outgoing magnitude
//   out_sign   outgoing sign
//   out_idx    edge number of the current message
//   out_last   high on the edge deg-1 message
// -----------------------------------------------------------------------------
module cn_expand #(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int deg    = 8,
    parameter int offset = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] min1,
    input  logic [data_w-1:0] min2,
    input  logic [idx_w-1:0]  min1_idx,
    input  logic [deg-1:0]    sign_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w-1:0] out_mag,
    output logic              out_sign,
    output logic [idx_w-1:0]  out_idx,
    output logic              out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

`ifdef CN_OFFSET_EN
    localparam bit off_en = 1'b1;
`else
    localparam bit off_en = 1'b0;
`endif

    // With the feature disabled the amount is zero, so the saturating
    // subtract below degenerates to a pass-through.
    localparam logic [data_w-1:0] off_amt = off_en ? data_w'(offset) : '0;
    localparam logic [idx_w-1:0]  last_e  = idx_w'(deg - 1);

    // ---------------------------------------------------------------------
    // State and latched record
    // ---------------------------------------------------------------------
    state_t              state_reg;
    logic [idx_w-1:0]    e_reg;
    logic [data_w-1:0]   min1_reg;
    logic [data_w-1:0]   min2_reg;
    logic [idx_w-1:0]    idx_reg;
    logic [deg-1:0]      sign_reg;
    logic                psign_reg;

    // Output registers
    logic                out_valid_reg;
    logic [data_w-1:0]   out_mag_reg;
    logic                out_sign_reg;
    logic [idx_w-1:0]    out_idx_reg;
    logic                out_last_reg;

    // ---------------------------------------------------------------------
    // Saturating subtract of the configured offset (never wraps below 0)
    // ---------------------------------------------------------------------
    function automatic logic [data_w-1:0] apply_offset(input logic [data_w-1:0] v);
        if (v >= off_amt) begin
            return v - off_amt;
        end
        return '0;
    endfunction

    // ---------------------------------------------------------------------
    // Next-message values
    //   fresh_* : edge 0 of the record currently on the input port
    //   adv_*   : edge e+1 of the latched record
    // ---------------------------------------------------------------------
    logic                load;
    logic                advance;
    logic                finish;
    logic                fresh_psign;
    logic [data_w-1:0]   fresh_mag;
    logic                fresh_sign;
    logic [idx_w-1:0]    adv_e;
    logic [deg-1:0]      adv_shift;
    logic [data_w-1:0]   adv_mag;
    logic                adv_sign;

    // The record is taken while idle, or in the same cycle the last edge
    // leaves so back-to-back records run without a bubble.
    assign in_ready = rst_n &&
                      ((state_reg == IDLE) ||
                       ((state_reg == EMIT) && out_last_reg && out_ready));

    assign load    = in_valid && in_ready;
    assign advance = (state_reg == EMIT) && out_ready && !out_last_reg;
    assign finish  = (state_reg == EMIT) && out_ready && out_last_reg;

    always_comb begin
        fresh_psign = ^sign_vec;
        fresh_mag   = apply_offset((min1_idx == '0) ? min2 : min1);
        fresh_sign  = fresh_psign ^ sign_vec[0];

        adv_e     = e_reg + 1'b1;
        // Shift rather than index so the edge counter width need not match
        // the bit-select width of the sign vector.
        adv_shift = sign_reg >> adv_e;
        adv_mag   = apply_offset((adv_e == idx_reg) ? min2_reg : min1_reg);
        adv_sign  = psign_reg ^ adv_shift[0];
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            e_reg         <= '0;
            min1_reg      <= '0;
            min2_reg      <= '0;
            idx_reg       <= '0;
            sign_reg      <= '0;
            psign_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_mag_reg   <= '0;
            out_sign_reg  <= 1'b0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            if (load) begin
                // New record: latch the summary and present edge 0 at once.
                state_reg     <= EMIT;
                e_reg         <= '0;
                min1_reg      <= min1;
                min2_reg      <= min2;
                idx_reg       <= min1_idx;
                sign_reg      <= sign_vec;
                psign_reg     <= fresh_psign;
                out_valid_reg <= 1'b1;
                out_mag_reg   <= fresh_mag;
                out_sign_reg  <= fresh_sign;
                out_idx_reg   <= '0;
                out_last_reg  <= (last_e == '0);
            end else if (advance) begin
                e_reg        <= adv_e;
                out_mag_reg  <= adv_mag;
                out_sign_reg <= adv_sign;
                out_idx_reg  <= adv_e;
                out_last_reg <= (adv_e == last_e);
            end else if (finish) begin
                // Last edge taken with no follow-on record.
                state_reg     <= IDLE;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_mag   = out_mag_reg;
    assign out_sign  = out_sign_reg;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_last_reg;

endmodule
